// File: rtl/minicpu_pkg.sv
// Shared definitions for the miniCPU data-port responder: MMIO register offsets
// and the region-select type.
package minicpu_pkg;

    localparam logic [15:0] MMIO_LED_OFS   = 16'h0000;
    localparam logic [15:0] MMIO_SW_OFS    = 16'h0004;
    localparam logic [15:0] MMIO_TIMER_OFS = 16'h0008;
    localparam logic [15:0] MMIO_WRCNT_OFS = 16'h000C;
    localparam logic [15:0] MMIO_SCR_OFS   = 16'h0010;

    typedef enum logic {
        RGN_RAM  = 1'b0,
        RGN_MMIO = 1'b1
    } rgn_e;

    // Only the upper half of the address selects MMIO; everything else is RAM.
    function automatic rgn_e decode_rgn(input logic [15:0] addr_hi, input logic [15:0] base_hi);
        decode_rgn = (addr_hi == base_hi) ? RGN_MMIO : RGN_RAM;
    endfunction

endpackage

// File: rtl/data_ram.sv
// Word RAM for the data port: asynchronous read, synchronous write, contents never reset.
module data_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [2**AW];

    assign rdata = mem_q[addr];

    // Write port; a read of the same word in the write cycle still sees the old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// Data-port responder: decodes CPU accesses into the word RAM or the MMIO bank.
// The TIMER register exists only when MMIO_TIMER_EN is defined.
module data_sram_resp
    import minicpu_pkg::*;
#(
    parameter int          RAM_AW    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [15:0] switch,
    output logic [15:0] led
);

    rgn_e        rgn_s;
    logic [15:0] ofs_s;
    logic        ram_we_s;
    logic        mmio_we_s;
    logic [31:0] ram_rdata_s;
    logic [31:0] mmio_rdata_s;
    logic [31:0] timer_rd_s;
    logic        unused_s;

    logic [15:0] led_q, led_d;
    logic [31:0] scr_q, scr_d;
    logic [31:0] wrcnt_q, wrcnt_d;
    logic [15:0] sw_meta_q, sw_sync_q;

    assign rgn_s     = decode_rgn(data_sram_addr[31:16], MMIO_BASE[31:16]);
    assign ofs_s     = {data_sram_addr[15:2], 2'b00};
    assign ram_we_s  = data_sram_we && resetn && (rgn_s == RGN_RAM);
    assign mmio_we_s = data_sram_we && resetn && (rgn_s == RGN_MMIO);
    assign unused_s  = ^data_sram_addr[1:0];

    data_ram #(.AW(RAM_AW)) u_data_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (data_sram_addr[RAM_AW+1:2]),
        .wdata (data_sram_wdata),
        .rdata (ram_rdata_s)
    );

`ifdef MMIO_TIMER_EN
    logic [31:0] timer_q, timer_d;

    // Free-running timer; a CPU write replaces this cycle's increment.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (mmio_we_s && (ofs_s == MMIO_TIMER_OFS)) begin
            timer_d = data_sram_wdata;
        end else begin
            timer_d = timer_q + 32'd1;
        end
    end

    // Timer register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            timer_q <= 32'd0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer_rd_s = timer_q;
`else
    assign timer_rd_s = 32'd0;
`endif

    // MMIO register next state; WRCNT counts RAM writes only and sticks at all-ones.
    always_comb begin
        led_d   = led_q;
        scr_d   = scr_q;
        wrcnt_d = wrcnt_q;
        if (mmio_we_s) begin
            case (ofs_s)
                MMIO_LED_OFS: led_d = data_sram_wdata[15:0];
                MMIO_SCR_OFS: scr_d = data_sram_wdata;
                default:      ;
            endcase
        end else begin
            led_d = led_q;
        end
        if (ram_we_s && (wrcnt_q != 32'hffff_ffff)) begin
            wrcnt_d = wrcnt_q + 32'd1;
        end else begin
            wrcnt_d = wrcnt_q;
        end
    end

    // MMIO registers and the two-stage switch synchronizer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            led_q     <= 16'd0;
            scr_q     <= 32'd0;
            wrcnt_q   <= 32'd0;
            sw_meta_q <= 16'd0;
            sw_sync_q <= 16'd0;
        end else begin
            led_q     <= led_d;
            scr_q     <= scr_d;
            wrcnt_q   <= wrcnt_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
        end
    end

    // MMIO read mux; unmapped offsets read as zero.
    always_comb begin
        mmio_rdata_s = 32'd0;
        case (ofs_s)
            MMIO_LED_OFS:   mmio_rdata_s = {16'd0, led_q};
            MMIO_SW_OFS:    mmio_rdata_s = {16'd0, sw_sync_q};
            MMIO_TIMER_OFS: mmio_rdata_s = timer_rd_s;
            MMIO_WRCNT_OFS: mmio_rdata_s = wrcnt_q;
            MMIO_SCR_OFS:   mmio_rdata_s = scr_q;
            default:        mmio_rdata_s = 32'd0;
        endcase
    end

    assign data_sram_rdata = (rgn_s == RGN_MMIO) ? mmio_rdata_s : ram_rdata_s;
    assign led             = led_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed scoreboard bench for data_sram_resp (default build, or with MMIO_TIMER_EN).
module tb_data_sram_resp;

    localparam logic [31:0] A_LED   = 32'hbfaf_0000;
    localparam logic [31:0] A_SW    = 32'hbfaf_0004;
    localparam logic [31:0] A_TIMER = 32'hbfaf_0008;
    localparam logic [31:0] A_WRCNT = 32'hbfaf_000c;
    localparam logic [31:0] A_SCR   = 32'hbfaf_0010;

    logic        clk;
    logic        resetn;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] switch_s;
    logic [15:0] led;

    int total;
    int bad;
    logic [31:0] exp_q[$];

    data_sram_resp dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch          (switch_s),
        .led             (led)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] e);
        we   = 1'b0;
        addr = a;
        exp_q.push_back(e);
        #1;
        check(tag, rdata);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        we    = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        resetn   = 1'b0;
        we       = 1'b0;
        addr     = 32'd0;
        wdata    = 32'd0;
        switch_s = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // reset state
        exp_q.push_back(32'd0);
        check("rst_led_pin", {16'd0, led});
        check_rd("rst_timer", A_TIMER, 32'd0);
        check_rd("rst_led", A_LED, 32'd0);
        check_rd("rst_wrcnt", A_WRCNT, 32'd0);
        check_rd("rst_scr", A_SCR, 32'd0);
        check_rd("rst_sw", A_SW, 32'd0);

        // 1: RAM write/read and write counter
        do_write(32'h0000_0010, 32'h1234_5678);
        check_rd("ram_rd", 32'h0000_0010, 32'h1234_5678);
        check_rd("wrcnt_1", A_WRCNT, 32'd1);

        // 2: read-during-write returns old data, new data next cycle
        do_write(32'h0000_0010, 32'h0000_000a);
        @(negedge clk);
        we    = 1'b1;
        addr  = 32'h0000_0010;
        wdata = 32'h0000_000b;
        exp_q.push_back(32'h0000_000a);
        #1;
        check("rdw_old", rdata);
        @(negedge clk);
        check_rd("rdw_new", 32'h0000_0010, 32'h0000_000b);
        check_rd("ram_alias", 32'h0000_1010, 32'h0000_000b);
        check_rd("wrcnt_3", A_WRCNT, 32'd3);

        // 3: LED takes effect at the write edge; SW is read-only
        @(negedge clk);
        we    = 1'b1;
        addr  = A_LED;
        wdata = 32'hffff_00ff;
        @(posedge clk);
        #1;
        exp_q.push_back(32'h0000_00ff);
        check("led_pin", {16'd0, led});
        @(negedge clk);
        check_rd("led_rd", A_LED, 32'h0000_00ff);
        do_write(A_SW, 32'h0000_1234);
        check_rd("sw_ro", A_SW, 32'd0);
        do_write(A_SCR, 32'hdead_beef);
        check_rd("scr_rd", A_SCR, 32'hdead_beef);
        check_rd("mmio_no_ram", 32'h0000_0010, 32'h0000_000b);
        do_write(32'hbfaf_0020, 32'h5555_aaaa);
        check_rd("unmapped", 32'hbfaf_0020, 32'd0);
        check_rd("wrcnt_mmio", A_WRCNT, 32'd3);

        // 4: switch synchronizer latency
        @(negedge clk);
        switch_s = 16'h8001;
        check_rd("sw_edge0", A_SW, 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(32'd0);
        check("sw_edge1", rdata);
        @(posedge clk);
        #1;
        exp_q.push_back(32'h0000_8001);
        check("sw_edge2", rdata);

        // 5: timer wrap, or timer absent
`ifdef MMIO_TIMER_EN
        do_write(A_TIMER, 32'hffff_fffe);
        check_rd("tmr_0", A_TIMER, 32'hffff_fffe);
        @(negedge clk);
        check_rd("tmr_1", A_TIMER, 32'hffff_ffff);
        @(negedge clk);
        check_rd("tmr_wrap", A_TIMER, 32'd0);
`else
        do_write(A_TIMER, 32'hffff_fffe);
        check_rd("tmr_absent", A_TIMER, 32'd0);
`endif

        // 6: reset mid-run with a write pending
        do_write(A_SCR, 32'h0000_0055);
        do_write(A_LED, 32'h0000_1234);
        do_write(32'h0000_0020, 32'h0000_cafe);
        check_rd("wrcnt_4", A_WRCNT, 32'd4);
        @(negedge clk);
        resetn = 1'b0;
        we     = 1'b1;
        addr   = 32'h0000_0020;
        wdata  = 32'h0000_0bad;
        @(negedge clk);
        resetn = 1'b1;
        we     = 1'b0;
        exp_q.push_back(32'd0);
        check("mid_led_pin", {16'd0, led});
        check_rd("mid_timer", A_TIMER, 32'd0);
        check_rd("mid_scr", A_SCR, 32'd0);
        check_rd("mid_wrcnt", A_WRCNT, 32'd0);
        check_rd("mid_ram_kept", 32'h0000_0020, 32'h0000_cafe);
        check_rd("mid_ram_old", 32'h0000_0010, 32'h0000_000b);
        check_rd("mid_led", A_LED, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
